// File: rtl/rr_priority_arbiter8.sv
// 8-client arbiter with fixed or rotating priority and a bounded hold time.
// The registered grant drives the select of the shared datapath mux.
module rr_priority_arbiter8 #(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       rr_mode,
    output logic [7:0] grant,
    output logic [2:0] grant_id,
    output logic       grant_valid,
    output logic       grant_start
);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    localparam logic [7:0] HOLD_LIMIT = 8'(MAX_HOLD);
    localparam bit         HOLD_BOUNDED = (MAX_HOLD != 0);

    state_t     state;
    state_t     state_next;
    logic [7:0] hold_cnt;
    logic [7:0] hold_next;
    logic [2:0] last_id;
    logic [2:0] last_next;
    logic [7:0] grant_next;
    logic [2:0] id_next;
    logic       start_next;
    logic       valid_next;

    logic [2:0] win_id;
    logic       win_found;
    logic       hold_expired;
    logic       release_now;

    // Priority search. Both loops let the highest-priority candidate overwrite
    // the others; in round-robin mode distance 1 below last_id is visited last,
    // and distance 8 (last_id itself) first, so the previous owner ranks lowest.
    always_comb begin
        logic [2:0] idx;
        idx       = '0;
        win_found = 1'b0;
        win_id    = '0;
        if (rr_mode) begin
            for (int k = 8; k >= 1; k--) begin
                idx = last_id - 3'(k);
                if (req[idx]) begin
                    win_found = 1'b1;
                    win_id    = idx;
                end
            end
        end else begin
            for (int k = 0; k < 8; k++) begin
                if (req[k]) begin
                    win_found = 1'b1;
                    win_id    = 3'(k);
                end
            end
        end
    end

    assign hold_expired = HOLD_BOUNDED && (hold_cnt == HOLD_LIMIT);
    assign release_now  = !req[grant_id] || hold_expired;

    always_comb begin
        state_next = state;
        grant_next = grant;
        id_next    = grant_id;
        start_next = 1'b0;
        valid_next = grant_valid;
        hold_next  = hold_cnt;
        last_next  = last_id;

        unique case (state)
            IDLE: begin
                if (win_found) begin
                    state_next = BUSY;
                    grant_next = 8'b1 << win_id;
                    id_next    = win_id;
                    start_next = 1'b1;
                    valid_next = 1'b1;
                    hold_next  = 8'd1;
                    last_next  = win_id;
                end else begin
                    grant_next = '0;
                    valid_next = 1'b0;
                    hold_next  = '0;
                end
            end

            BUSY: begin
                if (!release_now) begin
                    hold_next = (hold_cnt == 8'hFF) ? hold_cnt : hold_cnt + 8'd1;
                end else if (win_found) begin
                    grant_next = 8'b1 << win_id;
                    id_next    = win_id;
                    start_next = 1'b1;
                    valid_next = 1'b1;
                    hold_next  = 8'd1;
                    last_next  = win_id;
                end else begin
                    state_next = IDLE;
                    grant_next = '0;
                    valid_next = 1'b0;
                    hold_next  = '0;
                end
            end

            default: begin
                state_next = IDLE;
                grant_next = '0;
                valid_next = 1'b0;
                hold_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
            grant_start <= 1'b0;
            hold_cnt    <= '0;
            last_id     <= '0;
        end else begin
            state       <= state_next;
            grant       <= grant_next;
            grant_id    <= id_next;
            grant_valid <= valid_next;
            grant_start <= start_next;
            hold_cnt    <= hold_next;
            last_id     <= last_next;
        end
    end

endmodule

// File: doc/rr_priority_arbiter8.md
Name: rr_priority_arbiter8

Overview:
- 8-requester arbiter that shares one resource, for example a bus or a shared encoder/ALU slot, between up to 8 clients.
- Arbitration uses priority-encoder ordering, where the highest index wins. In round-robin mode that ordering rotates after each grant.
- Grants are registered and held until the owner releases or a hold limit expires.
- It sits between the requesting units and the shared datapath mux, and drives that mux's select.

Parameters:
- MAX_HOLD, 4: maximum consecutive cycles one grant may be held. 0 means unlimited. Legal range 0..255.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req  input  8  request vector; req[i]=1 means client i requests
- rr_mode  input  1  0 = fixed priority (7 highest, 0 lowest); 1 = round-robin
- grant  output  8  one-hot grant, registered; all zeros when idle
- grant_id  output  3  binary index of the current owner, valid when grant_valid=1
- grant_valid  output  1  1 while any grant is active
- grant_start  output  1  one-cycle pulse in the first cycle of every new grant, including a re-grant to the same client

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values:
  - grant=0, grant_id=0, grant_valid=0, grant_start=0
  - state=IDLE, hold_cnt=0
  - last_id=0, so the first round-robin search starts at index 7, identical to fixed priority.
- Internal state:
  - FSM with states IDLE and BUSY.
  - 8-bit hold_cnt.
  - 3-bit last_id, the most recently granted index.
- Arbitration function: pick(req, mode, last_id).
  - Fixed mode: highest set index of req.
  - RR mode: search descending from (last_id-1) mod 8, wrapping 0->7. last_id itself has lowest priority. The first set bit wins.
  - Result is "none" if req==0.
- IDLE:
  - If req!=0 at a clock edge, the winner from pick() is registered.
  - Next cycle: grant=onehot(winner), grant_id=winner, grant_valid=1, grant_start=1, hold_cnt=1, last_id=winner, state=BUSY.
  - Latency from req to grant is 1 cycle.
  - If req==0, remain in IDLE with all outputs 0.
- BUSY, release condition at an edge:
  - req[grant_id]==0, or
  - MAX_HOLD!=0 and hold_cnt==MAX_HOLD.
- BUSY, no release: keep the grant, grant_start=0, hold_cnt+=1. hold_cnt saturates at 255 when MAX_HOLD=0.
- BUSY, release: arbitrate in the same edge using pick().
  - In fixed mode, the current owner stays eligible if it still requests.
  - In RR mode, the current owner is lowest priority, because last_id==owner.
  - Winner exists: back-to-back grant with no idle gap. grant_valid stays 1, grant_start=1, hold_cnt=1, last_id updated.
  - No winner: next cycle grant=0, grant_valid=0, state=IDLE. grant_id keeps its last value (don't-care).
- A released client is never granted in the same cycle it dropped req.
  - Exception: a fixed-mode timeout with req still high re-grants the same index, shown by a grant_start pulse.
- Timing of grant width and hold:
  - With req held, the grant lasts exactly MAX_HOLD cycles.
  - On an early release, the grant drops (or moves) on the edge after req[grant_id] is seen low.
  - rr_mode and non-owner req changes are sampled only at arbitration edges.
  - Mid-grant changes to them do not affect the current owner.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid == |grant.
  - grant_id matches grant whenever grant_valid=1.
- Reset asserted mid-grant: on that edge, all outputs go to their reset values and last_id=0. Reset overrides all other inputs.

Test Plan:
1. Reset/idle:
   - Stimulus: reset=1 for 2 cycles with req=8'hFF, then req=0.
   - Response: grant=0, grant_valid=0, grant_start=0 throughout.
2. Single request, early release:
   - Stimulus: req=8'h04 for 2 cycles, then req=0, with MAX_HOLD=4.
   - Response: one cycle after req rises, grant=8'h04, grant_id=2, grant_start pulses once. Grant lasts 2 cycles, then grant_valid=0 and the FSM returns to IDLE.
3. Fixed priority:
   - Stimulus: rr_mode=0, req=8'h24 held, MAX_HOLD=2.
   - Response: grant_id=5 continuously. grant_start pulses every 2 cycles (re-grant); client 2 is never granted.
4. Round-robin fairness:
   - Stimulus: rr_mode=1, req=8'hFF held, MAX_HOLD=2.
   - Response: grant_id sequence 7,6,5,4,3,2,1,0,7. Each owner holds 2 cycles; grant_valid never drops.
5. RR skip and wrap:
   - Stimulus: rr_mode=1, req=8'h81, MAX_HOLD=1.
   - Response: grants alternate 7,0,7,0 every cycle, with grant_start=1 every cycle.
6. Reset mid-operation:
   - Stimulus: rr_mode=1, req=8'hFF; assert reset while grant_id=4, then release reset.
   - Response: outputs clear on the reset edge. After release, the first grant is 7, because last_id was reset to 0.
